// File: rtl/cclimb_input.sv
// cclimb_input: Crazy Climber control input adapter.
// Merges PS/2 keyboard and two HPS joystick words into two 4-way sticks with
// SOCD neutralisation, plus start/coin strobes. A frame-timed FSM turns a
// coin request into a fixed-length coin pulse followed by a lockout gap.
// Optional build macro CCLIMB_AUTOCOIN_EN: a start press in IDLE inserts a
// coin automatically and then replays that start as a timed pulse.
module cclimb_input #(
   parameter int COIN_FRAMES = 4
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [10:0] ps2_key,
   input  logic [15:0] joystick_0,
   input  logic [15:0] joystick_1,
   input  logic        vblank,
   output logic [3:0]  stick_l,
   output logic [3:0]  stick_r,
   output logic        start1,
   output logic        start2,
   output logic        coin1
);

   localparam logic [3:0] CF = 4'(COIN_FRAMES);

   typedef enum logic [1:0] {IDLE, COIN, GAP, START} coin_state_t;

   coin_state_t state;
   logic [3:0]  cnt;

   // Keyboard latches and toggle tracking
   logic        tog_q, primed;
   logic        kl_up, kl_dn, kl_lt, kl_rt;
   logic        kr_up, kr_dn, kr_lt, kr_rt;
   logic        ks1, ks2, kc;
   logic        key_evt;
   logic [7:0]  code;

   logic [15:0] joy;
   logic [3:0]  raw_l, raw_r;
   logic        raw_s1, raw_s2, coin_req;
   logic        vb_q, creq_q;
   logic        tick, coin_rise;
   logic        unused_bits;

`ifdef CCLIMB_AUTOCOIN_EN
   logic        s1_q, s2_q, s1_rise, s2_rise;
   logic        auto_q, sel2_q;
`endif

   // Opposing directions held together cancel to neutral on that axis
   function automatic logic [3:0] socd(input logic [3:0] r);
      return {r[3] & ~r[2], r[2] & ~r[3], r[1] & ~r[0], r[0] & ~r[1]};
   endfunction

   assign joy         = joystick_0 | joystick_1;
   // E0 prefix is deliberately not decoded: extended and plain codes alias
   assign code        = ps2_key[7:0];
   assign key_evt     = primed & (ps2_key[10] ^ tog_q);
   assign raw_l       = {kl_up, kl_dn, kl_lt, kl_rt} | joy[3:0];
   assign raw_r       = {kr_up, kr_dn, kr_lt, kr_rt} | joy[7:4];
   assign raw_s1      = ks1 | joystick_0[8];
   assign raw_s2      = ks2 | joystick_1[8] | joy[9];
   assign coin_req    = kc | joy[10];
   assign tick        = vblank & ~vb_q;
   assign coin_rise   = coin_req & ~creq_q;
   assign unused_bits = ^{joy[15:11], joy[8], ps2_key[8]};

`ifdef CCLIMB_AUTOCOIN_EN
   assign s1_rise     = raw_s1 & ~s1_q;
   assign s2_rise     = raw_s2 & ~s2_q;
`endif

   // Key decode: the first clock after reset only captures the toggle level
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         tog_q  <= 1'b0;
         primed <= 1'b0;
         kl_up  <= 1'b0; kl_dn <= 1'b0; kl_lt <= 1'b0; kl_rt <= 1'b0;
         kr_up  <= 1'b0; kr_dn <= 1'b0; kr_lt <= 1'b0; kr_rt <= 1'b0;
         ks1    <= 1'b0; ks2   <= 1'b0; kc    <= 1'b0;
      end else begin
         tog_q  <= ps2_key[10];
         primed <= 1'b1;
         if (key_evt) begin
            case (code)
               8'h1D: kl_up <= ps2_key[9];
               8'h1B: kl_dn <= ps2_key[9];
               8'h1C: kl_lt <= ps2_key[9];
               8'h23: kl_rt <= ps2_key[9];
               8'h75: kr_up <= ps2_key[9];
               8'h72: kr_dn <= ps2_key[9];
               8'h6B: kr_lt <= ps2_key[9];
               8'h74: kr_rt <= ps2_key[9];
               8'h05, 8'h16: ks1 <= ps2_key[9];
               8'h06, 8'h1E: ks2 <= ps2_key[9];
               8'h2E, 8'h36: kc  <= ps2_key[9];
               default: ;
            endcase
         end
      end
   end

   // Registered stick outputs after SOCD cleanup
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         stick_l <= 4'b0000;
         stick_r <= 4'b0000;
      end else begin
         stick_l <= socd(raw_l);
         stick_r <= socd(raw_r);
      end
   end

   // Previous-cycle copies for frame tick and request edge detection
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         vb_q   <= 1'b0;
         creq_q <= 1'b0;
`ifdef CCLIMB_AUTOCOIN_EN
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
`endif
      end else begin
         vb_q   <= vblank;
         creq_q <= coin_req;
`ifdef CCLIMB_AUTOCOIN_EN
         s1_q   <= raw_s1;
         s2_q   <= raw_s2;
`endif
      end
   end

   // Coin FSM with registered coin/start outputs; ticks count down each phase
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         coin1  <= 1'b0;
         start1 <= 1'b0;
         start2 <= 1'b0;
`ifdef CCLIMB_AUTOCOIN_EN
         auto_q <= 1'b0;
         sel2_q <= 1'b0;
`endif
      end else begin
         start1 <= raw_s1;
         start2 <= raw_s2;
         case (state)
            IDLE: begin
               if (coin_rise) begin
                  state <= COIN;
                  cnt   <= CF;
                  coin1 <= 1'b1;
`ifdef CCLIMB_AUTOCOIN_EN
                  auto_q <= 1'b0;
               end else if (s1_rise || s2_rise) begin
                  state  <= COIN;
                  cnt    <= CF;
                  coin1  <= 1'b1;
                  auto_q <= 1'b1;
                  sel2_q <= ~s1_rise;
                  start1 <= 1'b0;
                  start2 <= 1'b0;
`endif
               end
            end
            COIN: begin
`ifdef CCLIMB_AUTOCOIN_EN
               if (auto_q) begin
                  start1 <= 1'b0;
                  start2 <= 1'b0;
               end
`endif
               if (tick) begin
                  if (cnt <= 4'd1) begin
                     state <= GAP;
                     cnt   <= CF;
                     coin1 <= 1'b0;
                  end else begin
                     cnt <= cnt - 4'd1;
                  end
               end
            end
            GAP: begin
`ifdef CCLIMB_AUTOCOIN_EN
               if (auto_q) begin
                  start1 <= 1'b0;
                  start2 <= 1'b0;
               end
`endif
               if (tick) begin
                  if (cnt <= 4'd1) begin
`ifdef CCLIMB_AUTOCOIN_EN
                     if (auto_q) begin
                        state  <= START;
                        cnt    <= CF;
                        start1 <= ~sel2_q;
                        start2 <= sel2_q;
                     end else begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                     end
`else
                     state <= IDLE;
                     cnt   <= 4'd0;
`endif
                  end else begin
                     cnt <= cnt - 4'd1;
                  end
               end
            end
            START: begin
`ifdef CCLIMB_AUTOCOIN_EN
               start1 <= ~sel2_q;
               start2 <= sel2_q;
               if (tick) begin
                  if (cnt <= 4'd1) begin
                     state  <= IDLE;
                     cnt    <= 4'd0;
                     auto_q <= 1'b0;
                     start1 <= raw_s1;
                     start2 <= raw_s2;
                  end else begin
                     cnt <= cnt - 4'd1;
                  end
               end
`else
               state <= IDLE;
               cnt   <= 4'd0;
`endif
            end
            default: begin
               state <= IDLE;
               cnt   <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cclimb_input.sv
// tb_cclimb_input: scoreboard bench for cclimb_input (COIN_FRAMES = 4).
module tb_cclimb_input;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic [10:0] ps2_key;
   logic [15:0] joystick_0, joystick_1;
   logic        vblank;
   logic [3:0]  stick_l, stick_r;
   logic        start1, start2, coin1;
   logic [10:0] obs;

   int errors = 0;
   int checks = 0;
   int coin_pulses = 0;
   logic coin_q = 1'b0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];

   always #10 clk_sys = ~clk_sys;

   cclimb_input #(.COIN_FRAMES(4)) dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .ps2_key    (ps2_key),
      .joystick_0 (joystick_0),
      .joystick_1 (joystick_1),
      .vblank     (vblank),
      .stick_l    (stick_l),
      .stick_r    (stick_r),
      .start1     (start1),
      .start2     (start2),
      .coin1      (coin1)
   );

   assign obs = {stick_l, stick_r, start1, start2, coin1};

   always @(negedge clk_sys) begin
      coin_q <= coin1;
      if (coin1 && !coin_q) coin_pulses <= coin_pulses + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pack(input logic [3:0] l, input logic [3:0] r,
                                        input logic s1, input logic s2, input logic c);
      return {21'd0, l, r, s1, s2, c};
   endfunction

   task automatic push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic pop_check(input logic [31:0] got);
      exp_t e;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         check(e.tag, got, e.val);
      end
   endtask

   task automatic clk(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic send_key(input logic [8:0] code, input logic pressed);
      ps2_key = {~ps2_key[10], pressed, code};
   endtask

   // Each frame: sample outputs just before the vblank rise, then run 8 clocks
   task automatic frames(input int n, output int c_coin, output int c_s1,
                         output int c_s2, output int first_s2);
      c_coin = 0; c_s1 = 0; c_s2 = 0; first_s2 = -1;
      for (int i = 0; i < n; i++) begin
         if (coin1)  c_coin++;
         if (start1) c_s1++;
         if (start2) begin
            c_s2++;
            if (first_s2 < 0) first_s2 = i;
         end
         vblank = 1'b1;
         clk(3);
         vblank = 1'b0;
         clk(5);
      end
   endtask

   initial begin
      int nc, n1, n2, f2, p0;
      reset_n    = 1'b0;
      ps2_key    = 11'h400;
      joystick_0 = 16'h0000;
      joystick_1 = 16'h0000;
      vblank     = 1'b0;

      #25;
      push("reset_outputs", pack(4'b0, 4'b0, 0, 0, 0));
      pop_check({21'd0, obs});
      clk(3);
      reset_n = 1'b1;
      clk(5);
      push("toggle_high_at_release", pack(4'b0, 4'b0, 0, 0, 0));
      pop_check({21'd0, obs});

      // Joystick paths and SOCD
      joystick_0[3] = 1'b1; joystick_1[2] = 1'b1;
      push("socd_up_down", pack(4'b0000, 4'b0, 0, 0, 0));
      clk(1); pop_check({21'd0, obs});
      joystick_1[2] = 1'b0;
      push("up_after_release", pack(4'b1000, 4'b0, 0, 0, 0));
      clk(1); pop_check({21'd0, obs});
      joystick_0 = 16'h0003; joystick_1 = 16'h00A0;
      push("socd_lr_and_right_ul", pack(4'b0000, 4'b1010, 0, 0, 0));
      clk(1); pop_check({21'd0, obs});
      joystick_0 = 16'h0001; joystick_1 = 16'h0060;
      push("right_and_down_left", pack(4'b0001, 4'b0110, 0, 0, 0));
      clk(1); pop_check({21'd0, obs});
      joystick_0 = 16'h0000; joystick_1 = 16'h0000;
      clk(1);

      // PS/2 decode and latency
      send_key(9'h01D, 1'b1);
      push("ps2_one_clock", pack(4'b0, 4'b0, 0, 0, 0));
      clk(1); pop_check({21'd0, obs});
      push("ps2_up_pressed", pack(4'b1000, 4'b0, 0, 0, 0));
      clk(1); pop_check({21'd0, obs});
      send_key(9'h01D, 1'b0);
      push("ps2_up_released", pack(4'b0, 4'b0, 0, 0, 0));
      clk(2); pop_check({21'd0, obs});
      send_key(9'h175, 1'b1);
      push("ps2_e0_ignored", pack(4'b0, 4'b1000, 0, 0, 0));
      clk(2); pop_check({21'd0, obs});
      send_key(9'h0AA, 1'b1);
      push("ps2_undecoded", pack(4'b0, 4'b1000, 0, 0, 0));
      clk(2); pop_check({21'd0, obs});
      send_key(9'h075, 1'b0);
      push("ps2_right_up_off", pack(4'b0, 4'b0, 0, 0, 0));
      clk(2); pop_check({21'd0, obs});
      send_key(9'h01B, 1'b1);
      push("ps2_left_down", pack(4'b0100, 4'b0, 0, 0, 0));
      clk(2); pop_check({21'd0, obs});
      joystick_0[3] = 1'b1;
      push("socd_key_plus_joy", pack(4'b0000, 4'b0, 0, 0, 0));
      clk(1); pop_check({21'd0, obs});
      joystick_0 = 16'h0000;
      send_key(9'h01B, 1'b0);
      push("all_released", pack(4'b0, 4'b0, 0, 0, 0));
      clk(2); pop_check({21'd0, obs});

`ifdef CCLIMB_AUTOCOIN_EN
      // F2 inserts a coin, waits a gap, then pulses start2
      p0 = coin_pulses;
      send_key(9'h006, 1'b1);
      clk(2);
      send_key(9'h006, 1'b0);
      push("auto_coin_ticks", 32'd4);
      push("auto_start2_ticks", 32'd4);
      push("auto_start1_ticks", 32'd0);
      push("auto_gap_then_start2", 32'd8);
      push("auto_coin_pulses", 32'd1);
      frames(16, nc, n1, n2, f2);
      pop_check(32'(nc)); pop_check(32'(n2)); pop_check(32'(n1));
      pop_check(32'(f2)); pop_check(32'(coin_pulses - p0));
`else
      // Starts follow raw levels one clock later
      joystick_0[8] = 1'b1;
      push("start1_raw", pack(4'b0, 4'b0, 1, 0, 0));
      clk(1); pop_check({21'd0, obs});
      joystick_0 = 16'h0000; joystick_1[9] = 1'b1;
      push("start2_raw", pack(4'b0, 4'b0, 0, 1, 0));
      clk(1); pop_check({21'd0, obs});
      joystick_1 = 16'h0000;
      clk(1);
      p0 = coin_pulses;
      send_key(9'h006, 1'b1);
      push("f2_one_clock", pack(4'b0, 4'b0, 0, 0, 0));
      clk(1); pop_check({21'd0, obs});
      push("f2_start2", pack(4'b0, 4'b0, 0, 1, 0));
      clk(1); pop_check({21'd0, obs});
      send_key(9'h006, 1'b0);
      push("f2_no_coin_ticks", 32'd0);
      push("f2_no_coin_pulse", 32'd0);
      frames(6, nc, n1, n2, f2);
      pop_check(32'(nc)); pop_check(32'(coin_pulses - p0));
`endif

      // Held coin request yields one pulse of four ticks
      p0 = coin_pulses;
      joystick_0[10] = 1'b1;
      clk(1);
      push("coin_ticks", 32'd4);
      push("coin_pulses", 32'd1);
      push("coin_no_start2", 32'd0);
      frames(20, nc, n1, n2, f2);
      pop_check(32'(nc)); pop_check(32'(coin_pulses - p0)); pop_check(32'(n2));
      joystick_0 = 16'h0000;
      clk(2);

      // Reset during COIN drops coin1 immediately
      joystick_1[10] = 1'b1;
      clk(1);
      frames(2, nc, n1, n2, f2);
      push("coin_mid_sequence", 32'd1);
      pop_check({31'd0, coin1});
      #3 reset_n = 1'b0;
      #1;
      push("coin_async_drop", 32'd0);
      pop_check({31'd0, coin1});
      joystick_1 = 16'h0000;
      clk(2);
      reset_n = 1'b1;
      clk(3);
      push("after_reset_idle", pack(4'b0, 4'b0, 0, 0, 0));
      pop_check({21'd0, obs});
      p0 = coin_pulses;
      joystick_1[10] = 1'b1;
      clk(1);
      push("recoin_ticks", 32'd4);
      push("recoin_pulses", 32'd1);
      frames(12, nc, n1, n2, f2);
      pop_check(32'(nc)); pop_check(32'(coin_pulses - p0));
      joystick_1 = 16'h0000;
      clk(2);

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cclimb_input.md
CCLIMB_INPUT -- requirements
Module: cclimb_input

Interface
REQ-001 Parameter COIN_FRAMES, default 4, coin pulse / gap / forced-start length in frames, legal range 1-15.
REQ-002 clk_sys  in  1  system clock (48 MHz); all state on its rising edge.
REQ-003 reset_n  in  1  reset; asynchronous and active-low.
REQ-004 ps2_key  in  11  [10] toggle strobe, [9] pressed, [8:0] scancode with [8] = E0 extension.
REQ-005 joystick_0, joystick_1  in  16 each  HPS joystick words; joy = joystick_0 | joystick_1.
REQ-006 vblank  in  1  core vertical blank; each rising edge is one frame tick.
REQ-007 stick_l  out  4  left stick {up,down,left,right}, active-high.
REQ-008 stick_r  out  4  right stick {up,down,left,right}, active-high.
REQ-009 start1, start2, coin1  out  1 each  active-high, to the game core.

Function
REQ-010 Detect a key event when ps2_key[10] differs from its registered copy; ignore scancode bit 8 when decoding.
REQ-011 Decode on the event: 1D/1B/1C/23 set kl_up/down/left/right; 75/72/6B/74 set kr_up/down/left/right; 05 or 16 sets ks1; 06 or 1E sets ks2; 2E or 36 sets kc; each latch loads ps2_key[9].
REQ-012 Leave undecoded codes with no effect on any latch.
REQ-013 Raw left = kl OR joy{[3],[2],[1],[0]}; raw right = kr OR joy{[7],[6],[5],[4]}; raw s1 = ks1 | joystick_0[8]; raw s2 = ks2 | joystick_1[8] | joy[9]; coin request = kc | joy[10].
REQ-014 Per stick, drive both outputs of an axis 0 while up+down or left+right are raw-asserted together (SOCD neutral).
REQ-015 Register stick outputs: latency 1 clock from joystick input and 2 clocks from a PS/2 toggle edge.
REQ-016 Detect frame tick as vblank rising edge (registered copy, 1 clock latency).
REQ-017 Coin FSM states: IDLE, COIN, GAP, START; coin1 = 1 only in COIN.
REQ-018 IDLE -> COIN on a coin-request rising edge; load frame counter with COIN_FRAMES.
REQ-019 In COIN, GAP and START, decrement the counter on each frame tick and move to the next state when it reaches 0; START or GAP-exit without autocoin returns to IDLE.
REQ-020 Ignore coin and start rising edges while not in IDLE; a request held high produces exactly one pulse.
REQ-021 Coincident frame tick and state entry: the tick is not counted; the pulse lasts COIN_FRAMES full ticks after entry.
REQ-022 Outside the autocoin sequence, start1/start2 follow raw s1/s2 with 1-clock latency.

Reset
REQ-023 reset_n low: all outputs 0, all key latches 0, FSM IDLE, counter 0, vblank copy 0.
REQ-024 The first clock after reset_n release loads the ps2_key[10] copy without generating a key event.
REQ-025 reset_n asserted mid-sequence aborts it immediately; coin1 drops to 0 asynchronously.

Configuration
REQ-026 Macro CCLIMB_AUTOCOIN_EN defined: a raw s1 or s2 rising edge in IDLE enters COIN and records which start fired.
REQ-027 With CCLIMB_AUTOCOIN_EN defined, COIN -> GAP -> START -> IDLE; in START the recorded start output is forced 1 and both start outputs ignore raw levels from COIN entry until IDLE.
REQ-028 Macro not defined: start edges never enter the FSM; GAP exits to IDLE; START is unreachable.
REQ-029 Macro not defined: start outputs always follow raw levels.

Verification
REQ-030 Toggle ps2_key[10] with code 0x01D pressed -> stick_l = 1000 two clocks later; same toggle with pressed=0 -> 0000.
REQ-031 joystick_0[3] and joystick_1[2] both high -> stick_l up/down both 0; release [2] -> up = 1 next clock.
REQ-032 COIN_FRAMES=4; hold joy[10] for 20 frames -> coin1 high for exactly 4 vblank ticks, once.
REQ-033 ps2_key[10] = 1 at reset release, no further toggle -> no latch changes, all outputs 0.
REQ-034 CCLIMB_AUTOCOIN_EN defined; press F2 -> coin1 for 4 ticks, 4 ticks gap, start2 for 4 ticks, start1 stays 0.
REQ-035 Assert reset_n low during COIN -> coin1 = 0 at once; after release FSM IDLE and a new coin edge gives a full pulse.
